// File: rtl/fasta_streamer.sv
// FASTA sequence streamer: captures the first record as a 2-bit encoded query,
// then streams each database line's bases one per cycle with an end-of-line pulse.
module fasta_streamer #(
    parameter int MAX_QUERY = 50,
    parameter int LW        = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_restart,
    input  logic [7:0]             i_byte,
    input  logic                   i_byte_vld,
    output logic                   o_byte_rdy,
    output logic [0:2*MAX_QUERY-1] o_query,
    output logic [LW-1:0]          o_query_length,
    output logic                   o_query_vld,
    output logic                   o_vld,
    output logic [1:0]             o_data,
    output logic                   o_seq_end,
    output logic                   o_err
);

    typedef enum logic [2:0] {
        Q_HDR, Q_SKIP, Q_SEQ, DB_LINE, DB_SKIP, DB, GAP
    } state_t;

    state_t                   r_state;
    logic [0:2*MAX_QUERY-1]   r_query;
    logic [LW-1:0]            r_len;
    logic                     r_query_vld;
    logic                     r_vld;
    logic [1:0]               r_data;
    logic                     r_seq_end;
    logic                     r_err;

    logic                     w_accept;
    logic                     w_is_lf;
    logic                     w_is_cr;
    logic                     w_is_gt;
    logic                     w_is_base;
    logic [1:0]               w_code;

    assign o_byte_rdy = (r_state != GAP);
    assign w_accept   = i_byte_vld & o_byte_rdy;
    assign w_is_lf    = (i_byte == 8'h0A);
    assign w_is_cr    = (i_byte == 8'h0D);
    assign w_is_gt    = (i_byte == 8'h3E);

    always_comb begin
        w_is_base = 1'b1;
        w_code    = 2'b00;
        case (i_byte)
            8'h41, 8'h61: w_code = 2'b00;
            8'h47, 8'h67: w_code = 2'b01;
            8'h54, 8'h74: w_code = 2'b10;
            8'h43, 8'h63: w_code = 2'b11;
            default:      w_is_base = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= Q_HDR;
            r_query     <= '0;
            r_len       <= '0;
            r_query_vld <= 1'b0;
            r_vld       <= 1'b0;
            r_data      <= 2'b00;
            r_seq_end   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_vld     <= 1'b0;
            r_seq_end <= 1'b0;
            // Restart outranks GAP and any concurrent byte, which is left unconsumed.
            if (i_restart) begin
                r_state     <= Q_HDR;
                r_query_vld <= 1'b0;
            end else if (r_state == GAP) begin
                r_state <= DB_LINE;
            end else if (w_accept && !w_is_cr) begin
                case (r_state)
                    Q_HDR: begin
                        if (w_is_gt) r_state <= Q_SKIP;
                    end
                    Q_SKIP: begin
                        if (w_is_lf) begin
                            r_state <= Q_SEQ;
                            r_query <= '0;
                            r_len   <= '0;
                        end
                    end
                    Q_SEQ: begin
                        if (w_is_lf) begin
                            if (r_len != '0) begin
                                r_query_vld <= 1'b1;
                                r_state     <= DB_LINE;
                            end
                        end else if (w_is_base) begin
                            if (r_len == LW'(MAX_QUERY)) begin
                                r_err <= 1'b1;
                            end else begin
                                for (int unsigned k = 0; k < MAX_QUERY; k++) begin
                                    if (k == 32'(r_len)) r_query[2*k +: 2] <= w_code;
                                end
                                r_len <= r_len + 1'b1;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    DB_LINE: begin
                        if (w_is_gt) begin
                            r_state <= DB_SKIP;
                        end else if (w_is_base) begin
                            r_vld   <= 1'b1;
                            r_data  <= w_code;
                            r_state <= DB;
                        end else if (!w_is_lf) begin
                            r_err <= 1'b1;
                        end
                    end
                    DB_SKIP: begin
                        if (w_is_lf) r_state <= DB_LINE;
                    end
                    DB: begin
                        if (w_is_base) begin
                            r_vld  <= 1'b1;
                            r_data <= w_code;
                        end else if (w_is_lf) begin
                            r_state   <= GAP;
                            r_seq_end <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: r_state <= Q_HDR;
                endcase
            end
        end
    end

    assign o_query        = r_query;
    assign o_query_length = r_len;
    assign o_query_vld    = r_query_vld;
    assign o_vld          = r_vld;
    assign o_data         = r_data;
    assign o_seq_end      = r_seq_end;
    assign o_err          = r_err;

endmodule

// File: tb/tb_fasta_streamer.sv
// Directed bench for fasta_streamer: a vector table for the main byte flow plus
// hand sequences for query overflow and asynchronous reset mid-line.
module tb_fasta_streamer;

    localparam int MQ = 50;
    localparam int LW = 6;

    logic              clk;
    logic              rst;
    logic              i_restart;
    logic [7:0]        i_byte;
    logic              i_byte_vld;
    logic              o_byte_rdy;
    logic [0:2*MQ-1]   o_query;
    logic [LW-1:0]     o_query_length;
    logic              o_query_vld;
    logic              o_vld;
    logic [1:0]        o_data;
    logic              o_seq_end;
    logic              o_err;

    fasta_streamer #(.MAX_QUERY(MQ), .LW(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_restart      (i_restart),
        .i_byte         (i_byte),
        .i_byte_vld     (i_byte_vld),
        .o_byte_rdy     (o_byte_rdy),
        .o_query        (o_query),
        .o_query_length (o_query_length),
        .o_query_vld    (o_query_vld),
        .o_vld          (o_vld),
        .o_data         (o_data),
        .o_seq_end      (o_seq_end),
        .o_err          (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic        v;
        logic        rs;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;

    // {rdy, vld, data, seq_end, query_vld, err, query_length}
    function automatic logic [12:0] ex(logic rdy, logic vld, logic [1:0] d,
                                       logic se, logic qv, logic err, logic [5:0] ql);
        return {rdy, vld, d, se, qv, err, ql};
    endfunction

    function automatic logic [12:0] snap();
        return {o_byte_rdy, o_vld, o_data, o_seq_end, o_query_vld, o_err, o_query_length};
    endfunction

    task automatic add(logic [7:0] b, logic v, logic rs, logic rdy, logic vld,
                       logic [1:0] d, logic se, logic qv, logic err, logic [5:0] ql);
        vec_t t;
        t.b = b; t.v = v; t.rs = rs; t.exp = ex(rdy, vld, d, se, qv, err, ql);
        vecs.push_back(t);
    endtask

    task automatic chk(string name, logic [12:0] got, logic [12:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got rdy/vld/data/se/qv/err/qlen=%b required %b", name, got, want);
        end
    endtask

    task automatic chkq(string name, logic [0:2*MQ-1] got, logic [0:2*MQ-1] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got query=%h required %h", name, got, want);
        end
    endtask

    task automatic step(logic [7:0] b, logic v, logic rs);
        i_byte = b; i_byte_vld = v; i_restart = rs;
        @(posedge clk);
        #1;
    endtask

    logic [0:2*MQ-1] eq;
    logic [7:0]      bases [4];

    initial begin
        bases = '{8'h41, 8'h47, 8'h54, 8'h43};
        rst = 1'b1; i_restart = 1'b0; i_byte = 8'h00; i_byte_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", snap(), ex(1, 0, 2'b00, 0, 0, 0, 0));
        chkq("reset_query", o_query, '0);
        rst = 1'b0;

        // query ">q\nAGTC\n"
        add(">", 1, 0, 1, 0, 2'b00, 0, 0, 0, 0);
        add("q", 1, 0, 1, 0, 2'b00, 0, 0, 0, 0);
        add(LF,  1, 0, 1, 0, 2'b00, 0, 0, 0, 0);
        add("A", 1, 0, 1, 0, 2'b00, 0, 0, 0, 1);
        add("G", 1, 0, 1, 0, 2'b00, 0, 0, 0, 2);
        add("T", 1, 0, 1, 0, 2'b00, 0, 0, 0, 3);
        add("C", 1, 0, 1, 0, 2'b00, 0, 0, 0, 4);
        add(LF,  1, 0, 1, 0, 2'b00, 0, 1, 0, 4);
        // database ">d\ngaTC\n"
        add(">", 1, 0, 1, 0, 2'b00, 0, 1, 0, 4);
        add("d", 1, 0, 1, 0, 2'b00, 0, 1, 0, 4);
        add(LF,  1, 0, 1, 0, 2'b00, 0, 1, 0, 4);
        add("g", 1, 0, 1, 1, 2'b01, 0, 1, 0, 4);
        add("a", 1, 0, 1, 1, 2'b00, 0, 1, 0, 4);
        add("T", 1, 0, 1, 1, 2'b10, 0, 1, 0, 4);
        add("C", 1, 0, 1, 1, 2'b11, 0, 1, 0, 4);
        add(LF,  1, 0, 0, 0, 2'b11, 1, 1, 0, 4);
        add(0,   0, 0, 1, 0, 2'b11, 0, 1, 0, 4);
        // CR, empty line and invalid byte in DB_LINE produce nothing
        add(CR,  1, 0, 1, 0, 2'b11, 0, 1, 0, 4);
        add(LF,  1, 0, 1, 0, 2'b11, 0, 1, 0, 4);
        add("A", 0, 0, 1, 0, 2'b11, 0, 1, 0, 4);
        // "AXG\n"
        add("A", 1, 0, 1, 1, 2'b00, 0, 1, 0, 4);
        add("X", 1, 0, 1, 0, 2'b00, 0, 1, 1, 4);
        add("G", 1, 0, 1, 1, 2'b01, 0, 1, 1, 4);
        add(LF,  1, 0, 0, 0, 2'b01, 1, 1, 1, 4);
        // byte offered during GAP is not taken
        add("C", 1, 0, 1, 0, 2'b01, 0, 1, 1, 4);
        add("T", 1, 0, 1, 1, 2'b10, 0, 1, 1, 4);
        add(LF,  1, 0, 0, 0, 2'b10, 1, 1, 1, 4);
        // restart during GAP
        add("A", 1, 1, 1, 0, 2'b10, 0, 0, 1, 4);
        // restart with '>' must not consume it: following LF/A leave length at 4
        add(">", 1, 1, 1, 0, 2'b10, 0, 0, 1, 4);
        add(LF,  1, 0, 1, 0, 2'b10, 0, 0, 1, 4);
        add("A", 1, 0, 1, 0, 2'b10, 0, 0, 1, 4);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].b, vecs[i].v, vecs[i].rs);
            chk($sformatf("vec%0d", i), snap(), vecs[i].exp);
        end
        eq = '0;
        eq[0:7] = 8'b00011011;
        chkq("query_AGTC", o_query, eq);

        // query overflow: 52 bases into a 50-base store
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(">", 1, 0);
        step(LF, 1, 0);
        step(LF, 1, 0);
        chk("empty_query_line", snap(), ex(1, 0, 2'b00, 0, 0, 0, 0));
        eq = '0;
        for (int i = 0; i < 52; i++) begin
            if (i < MQ) eq[2*i +: 2] = 2'(i % 4);
            step(bases[i % 4], 1, 0);
            chk($sformatf("ovf_base%0d", i), snap(),
                ex(1, 0, 2'b00, 0, 0, (i >= MQ), 6'((i + 1 < MQ) ? i + 1 : MQ)));
        end
        chkq("ovf_query", o_query, eq);
        step(LF, 1, 0);
        chk("ovf_query_vld", snap(), ex(1, 0, 2'b00, 0, 1, 1, 6'(MQ)));

        // async reset mid database line
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(">", 1, 0);
        step(LF, 1, 0);
        step("A", 1, 0);
        step(LF, 1, 0);
        step("A", 1, 0);
        step("C", 1, 0);
        chk("pre_reset", snap(), ex(1, 1, 2'b11, 0, 1, 0, 1));
        #2 rst = 1'b1;
        #1;
        chk("async_reset", snap(), ex(1, 0, 2'b00, 0, 0, 0, 0));
        chkq("async_reset_query", o_query, '0);
        rst = 1'b0;
        step("G", 1, 0);
        chk("post_reset_G", snap(), ex(1, 0, 2'b00, 0, 0, 0, 0));
        step("T", 1, 0);
        chk("post_reset_T", snap(), ex(1, 0, 2'b00, 0, 0, 0, 0));
        step(LF, 1, 0);
        chk("post_reset_LF", snap(), ex(1, 0, 2'b00, 0, 0, 0, 0));
        step(0, 0, 0);
        chk("post_reset_idle", snap(), ex(1, 0, 2'b00, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fasta_streamer.md
FASTA_STREAMER -- requirements
Module: fasta_streamer

Interface
REQ-001 SHALL have parameter MAX_QUERY, default 50, maximum query bases held.
REQ-002 SHALL have parameter LW, default 6, query-length width; the value SHALL be at least clog2(MAX_QUERY+1).
REQ-003 SHALL have port clk  in  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_restart  in  1  synchronous: abandon the current file and return to the query-header search.
REQ-006 SHALL have port i_byte  in  8  ASCII character from the sequence file.
REQ-007 SHALL have port i_byte_vld  in  1  i_byte is valid.
REQ-008 SHALL have port o_byte_rdy  out  1  block accepts i_byte this cycle.
REQ-009 SHALL have port o_query  out  2*MAX_QUERY  query bitstream; base k at bits [2k+:2] of an ascending [0:2*MAX_QUERY-1] vector.
REQ-010 SHALL have port o_query_length  out  LW  number of query bases stored.
REQ-011 SHALL have port o_query_vld  out  1  query complete and stable.
REQ-012 SHALL have port o_vld  out  1  o_data holds a database base.
REQ-013 SHALL have port o_data  out  2  encoded database base.
REQ-014 SHALL have port o_seq_end  out  1  one-cycle pulse after the last base of a database line.
REQ-015 SHALL have port o_err  out  1  sticky flag: illegal character or query overflow.

Function
REQ-016 A byte SHALL be accepted only on a rising edge where i_byte_vld=1 and o_byte_rdy=1.
REQ-017 Base encoding SHALL be: A/a=00, G/g=01, T/t=10, C/c=11.
REQ-018 CR (0x0D) SHALL be ignored in every state; LF (0x0A) is the line terminator.
REQ-019 FSM states: Q_HDR, Q_SKIP, Q_SEQ, DB_LINE, DB_SKIP, DB, GAP.
REQ-020 Q_HDR: '>' -> Q_SKIP; all other bytes SHALL be discarded.
REQ-021 Q_SKIP: LF -> Q_SEQ, clearing o_query and o_query_length; other bytes SHALL be discarded.
REQ-022 Q_SEQ, base: SHALL write the base at index o_query_length and then increment; once length equals MAX_QUERY, further bases SHALL be dropped and o_err set.
REQ-023 Q_SEQ, LF with length>0: SHALL set o_query_vld=1 and go to DB_LINE; LF with length=0 SHALL stay in Q_SEQ.
REQ-024 o_query and o_query_length SHALL remain unchanged while o_query_vld=1.
REQ-025 DB_LINE: '>' -> DB_SKIP; base -> emit it and go to DB; LF -> stay.
REQ-026 DB_SKIP: LF -> DB_LINE; other bytes SHALL be discarded.
REQ-027 DB: base -> emit it; LF -> GAP.
REQ-028 Emit: a base accepted at edge n SHALL give o_vld=1 and o_data=code in the cycle after edge n (1-cycle latency, registered); otherwise o_vld=0.
REQ-029 o_data SHALL hold its last value when o_vld=0.
REQ-030 GAP SHALL last exactly one cycle with o_byte_rdy=0, o_vld=0 and o_seq_end=1, then go to DB_LINE.
REQ-031 o_byte_rdy SHALL be 1 in every state except GAP.
REQ-032 A non-base, non-LF, non-CR byte in Q_SEQ, DB_LINE or DB SHALL be dropped and set o_err; the state SHALL be unchanged and o_vld=0.
REQ-033 i_restart=1 SHALL force Q_HDR and clear o_query_vld, o_vld and o_seq_end on the next edge, even in GAP; o_err SHALL be kept; the concurrent byte SHALL not be consumed.

Reset
REQ-034 rst=1 SHALL immediately force state Q_HDR and o_query=0, o_query_length=0, o_query_vld=0, o_vld=0, o_data=00, o_seq_end=0, o_err=0.
REQ-035 o_byte_rdy SHALL be 1 during reset.
REQ-036 Reset asserted mid-line SHALL discard the partial line, and no o_vld or o_seq_end SHALL follow.

Verification
REQ-037 Bytes ">q\nAGTC\n" -> o_query[0:7]=00_01_10_11, o_query_length=4, o_query_vld=1 one cycle after the LF; no o_vld pulses.
REQ-038 Then ">d\ngaTC\n", bytes every cycle -> o_vld high for 4 consecutive cycles with o_data 01,00,10,11; next cycle o_seq_end=1, o_byte_rdy=0; o_err=0.
REQ-039 A 52-base query line with MAX_QUERY=50 -> o_query_length=50, the first 50 bases stored, o_err=1.
REQ-040 Database line "AXG\n" -> o_data 00 then 01 with one o_vld=0 cycle between, o_err=1, then one o_seq_end pulse.
REQ-041 rst pulsed after the 2nd base of "ACGT" -> all outputs at reset values at once; the remaining "GT\n" is consumed in Q_HDR with no output.
REQ-042 i_restart during GAP -> Q_HDR on the next edge, o_query_vld=0, o_seq_end=0, o_err unchanged.
